pe_array_drain: RTL and testbench

//  Reader/drain for the PE array accumulator grid. On start, snapshots every acc_out[x][y],

---
 rtl/pe_array_drain_pkg.sv | 20 ++
 rtl/pe_array_drain_if.sv | 14 +
 rtl/pe_array_drain_requant.sv | 37 +++
 rtl/pe_array_drain.sv | 117 +++++++++++
 tb/tb_pe_array_drain.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_array_drain_pkg.sv
// Shared definitions for the PE array drain: default widths, drain FSM state
// encoding and the signed saturation bounds for the default activation width.
package pe_array_pkg;

  localparam int DEF_ACTIVATION_WIDTH  = 16;
  localparam int DEF_ACCUMULATOR_WIDTH = 40;
  localparam int DEF_ARRAY_X           = 4;
  localparam int DEF_ARRAY_Y           = 4;
  localparam int DEF_ADDR_WIDTH        = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

  localparam int ACT_MAX = (2 ** (DEF_ACTIVATION_WIDTH - 1)) - 1;
  localparam int ACT_MIN = -(2 ** (DEF_ACTIVATION_WIDTH - 1));

endpackage

// File: rtl/pe_array_drain_if.sv
// Output buffer write port: valid/ready handshake with address and data.
// master = drain side, slave = output SRAM side.
interface pe_array_drain_if #(
  parameter int addr_width       = 16,
  parameter int activation_width = 16
);
  logic                               wr_valid;
  logic                               wr_ready;
  logic [addr_width-1:0]              wr_addr;
  logic signed [activation_width-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/pe_array_drain_requant.sv
// Combinational requantizer: arithmetic right shift (floor), optional ReLU,
// then signed saturation to activation_width.
// Build option: RELU_EN clamps negative shifted values to zero before saturation.
module pe_requant_sat
  import pe_array_pkg::*;
#(
  parameter int activation_width  = DEF_ACTIVATION_WIDTH,
  parameter int accumulator_width = DEF_ACCUMULATOR_WIDTH
) (
  input  logic signed [accumulator_width-1:0]       acc,
  input  logic        [$clog2(accumulator_width)-1:0] shift,
  output logic signed [activation_width-1:0]        q
);

  localparam logic signed [accumulator_width-1:0] SAT_MAX =
    {{(accumulator_width-activation_width+1){1'b0}}, {(activation_width-1){1'b1}}};
  localparam logic signed [accumulator_width-1:0] SAT_MIN =
    {{(accumulator_width-activation_width+1){1'b1}}, {(activation_width-1){1'b0}}};

  logic signed [accumulator_width-1:0] shifted;
  logic signed [accumulator_width-1:0] clipped;

  assign shifted = acc >>> shift;

  // optional rectification followed by clamp into the activation range
  always_comb begin
`ifdef RELU_EN
    clipped = shifted[accumulator_width-1] ? '0 : shifted;
`else
    clipped = shifted;
`endif
    if (clipped > SAT_MAX)      q = SAT_MAX[activation_width-1:0];
    else if (clipped < SAT_MIN) q = SAT_MIN[activation_width-1:0];
    else                        q = clipped[activation_width-1:0];
  end

endmodule

// File: rtl/pe_array_drain.sv
// PE array accumulator drain. On start, snapshots the whole accumulator grid,
// pulses pe_clear once, then streams requantized elements in x-major order
// to the output buffer write port at base_addr + idx (address wraps).
// Build option: RELU_EN (see pe_requant_sat) zeroes negative results.
//
// state | meaning
// IDLE  | waiting for start; write port idle
// DRAIN | presenting element idx, advancing on each handshake
// DONE  | one-cycle done pulse, busy already low
module pe_array_drain
  import pe_array_pkg::*;
#(
  parameter int activation_width  = DEF_ACTIVATION_WIDTH,
  parameter int accumulator_width = DEF_ACCUMULATOR_WIDTH,
  parameter int array_x           = DEF_ARRAY_X,
  parameter int array_y           = DEF_ARRAY_Y,
  parameter int addr_width        = DEF_ADDR_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   start,
  input  logic        [addr_width-1:0]           base_addr,
  input  logic        [$clog2(accumulator_width)-1:0] shift,
  input  logic signed [accumulator_width-1:0]    acc_in [array_x][array_y],
  output logic                                   pe_clear,
  pe_array_drain_if.master                       wr,
  output logic                                   busy,
  output logic                                   done
);

  localparam int N     = array_x * array_y;
  localparam int IDX_W = $clog2(N);
  localparam int SH_W  = $clog2(accumulator_width);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]                          state;
  logic [IDX_W-1:0]                    idx;
  logic [addr_width-1:0]               base_q;
  logic [SH_W-1:0]                     shift_q;
  logic signed [accumulator_width-1:0] snap [N];
  logic signed [activation_width-1:0]  q_w;

  // snapshot bank: flattened x-major so idx selects the element directly
  for (genvar gx = 0; gx < array_x; gx++) begin : g_x
    for (genvar gy = 0; gy < array_y; gy++) begin : g_y
      // capture one accumulator when a drain is accepted
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                           snap[gx*array_y+gy] <= '0;
        else if (state == S_IDLE && start)   snap[gx*array_y+gy] <= acc_in[gx][gy];
      end
    end
  end

  // drain sequencing, handshake tracking and status pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      idx         <= '0;
      base_q      <= '0;
      shift_q     <= '0;
      pe_clear    <= 1'b0;
      wr.wr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      pe_clear <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_DRAIN;
            idx         <= '0;
            base_q      <= base_addr;
            shift_q     <= shift;
            pe_clear    <= 1'b1;
            wr.wr_valid <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (wr.wr_ready) begin
            if (idx == LAST) begin
              state       <= S_DONE;
              wr.wr_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          idx   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  pe_requant_sat #(
    .activation_width (activation_width),
    .accumulator_width(accumulator_width)
  ) u_requant (
    .acc  (snap[idx]),
    .shift(shift_q),
    .q    (q_w)
  );

  assign wr.wr_data = q_w;
  assign wr.wr_addr = base_q + {{(addr_width-IDX_W){1'b0}}, idx};

endmodule

// File: tb/tb_pe_array_drain.sv
// Bench for pe_array_drain: scenario tasks driving randomized grids against a
// floor-shift / clamp reference model of the requantization and address rules.
module tb_pe_array_drain;

  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic [15:0]        base_addr;
  logic [5:0]         shift;
  logic signed [39:0] acc [4][4];
  logic               pe_clear;
  logic               busy;
  logic               done;

  pe_array_drain_if #(.addr_width(16), .activation_width(16)) wr_if ();

  pe_array_drain dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .base_addr(base_addr),
    .shift    (shift),
    .acc_in   (acc),
    .pe_clear (pe_clear),
    .wr       (wr_if),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int  hs_addr[$];
  int  hs_data[$];
  int  done_cycle, clear_count, clear_cycle, stall_errs, busy_errs;
  bit  timed_out;
  logic signed [39:0] snap_ref [4][4];

  // reference requantization: floor shift, optional ReLU, clamp to 16-bit signed
  function automatic int model_q(input logic signed [39:0] a, input int sh);
    longint v;
    v = a;
    v = v >>> sh;
`ifdef RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return int'(v);
  endfunction

  function automatic logic signed [39:0] rand_acc();
    if ($urandom_range(0, 1) == 1) return 40'({$urandom(), $urandom()});
    return 40'(longint'($urandom_range(0, 400000)) - 200000);
  endfunction

  // Runs one drain and records what the write port did (no checking here).
  // mode 0: always ready, 1: ready every third cycle, 2: random ready.
  task automatic run_drain(input logic [15:0] base, input logic [5:0] sh, input int mode,
                           input bit poke, input int abort_after);
    bit rdy, prev_stall;
    int p_addr, p_data;
    hs_addr.delete(); hs_data.delete();
    done_cycle = -1; clear_count = 0; clear_cycle = -1;
    stall_errs = 0; busy_errs = 0; timed_out = 1; prev_stall = 0;
    p_addr = 0; p_data = 0;
    @(negedge clk);
    snap_ref = acc;
    base_addr = base; shift = sh; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) acc[i/4][i%4] = rand_acc();
    for (int cyc = 1; cyc <= 300; cyc++) begin
      start = 1'b0;
      if (poke && cyc == 3) begin start = 1'b1; base_addr = 16'h1234; shift = 6'd3; end
      if (abort_after >= 0 && hs_addr.size() == abort_after) begin timed_out = 0; return; end
      if (pe_clear === 1'b1) begin clear_count++; clear_cycle = cyc; end
      if (done === 1'b1) begin
        done_cycle = cyc; timed_out = 0;
        if (busy !== 1'b0 || wr_if.wr_valid !== 1'b0) busy_errs++;
        if (poke) start = 1'b1;
        return;
      end
      if (busy !== 1'b1) busy_errs++;
      if (wr_if.wr_valid !== 1'b1) stall_errs++;
      else if (prev_stall && (int'(wr_if.wr_addr) != p_addr || int'($signed(wr_if.wr_data)) != p_data))
        stall_errs++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      wr_if.wr_ready = rdy;
      p_addr = int'(wr_if.wr_addr);
      p_data = int'($signed(wr_if.wr_data));
      if (wr_if.wr_valid === 1'b1 && rdy) begin hs_addr.push_back(p_addr); hs_data.push_back(p_data); end
      prev_stall = (wr_if.wr_valid === 1'b1) && !rdy;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1; start = 1'b0; wr_if.wr_ready = 1'b0; base_addr = 16'h5A5A; shift = 6'd7;
    for (int i = 0; i < 16; i++) acc[i/4][i%4] = rand_acc();
    #3 rstn = 1'b0;
    #1;
    n_checks++; if ({pe_clear, wr_if.wr_valid, busy, done} !== 4'b0) begin n_fail++;
      $display("FAIL reset_ctrl got %b exp 0000", {pe_clear, wr_if.wr_valid, busy, done}); end
    n_checks++; if (wr_if.wr_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0000", wr_if.wr_addr); end
    n_checks++; if (wr_if.wr_data !== 16'sh0) begin n_fail++; $display("FAIL reset_data got %h exp 0000", wr_if.wr_data); end
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({wr_if.wr_valid, busy} !== 2'b00) begin n_fail++;
      $display("FAIL reset_hold got %b exp 00", {wr_if.wr_valid, busy}); end
    start = 1'b0;
    rstn = 1'b1;
    wr_if.wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({wr_if.wr_valid, busy, done} !== 3'b000) begin n_fail++;
      $display("FAIL idle_ready_ignored got %b exp 000", {wr_if.wr_valid, busy, done}); end
  endtask

  task automatic test_ramp();
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++) acc[x][y] = 40'((4*x + y) * 256);
    run_drain(16'h0100, 6'd8, 0, 1'b0, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL ramp_timeout got timeout exp done"); end
    n_checks++; if (hs_addr.size() != 16) begin n_fail++; $display("FAIL ramp_count got %0d exp 16", hs_addr.size()); end
    for (int i = 0; i < hs_addr.size() && i < 16; i++) begin
      n_checks++; if (hs_data[i] != i) begin n_fail++; $display("FAIL ramp_data[%0d] got %0d exp %0d", i, hs_data[i], i); end
      n_checks++; if (hs_addr[i] != 16'h0100 + i) begin n_fail++;
        $display("FAIL ramp_addr[%0d] got %h exp %h", i, hs_addr[i], 16'h0100 + i); end
    end
    n_checks++; if (done_cycle != 17) begin n_fail++; $display("FAIL ramp_done_cycle got %0d exp 17", done_cycle); end
    n_checks++; if (clear_count != 1 || clear_cycle != 1) begin n_fail++;
      $display("FAIL ramp_clear got count %0d cycle %0d exp 1 at 1", clear_count, clear_cycle); end
    n_checks++; if (busy_errs != 0 || stall_errs != 0) begin n_fail++;
      $display("FAIL ramp_busy_valid got %0d/%0d errs exp 0/0", busy_errs, stall_errs); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) acc[i/4][i%4] = rand_acc();
    acc[0][0] = 40'h0000100000;
    acc[0][1] = -40'sd1000000;
    acc[0][2] = -40'sd3;
    run_drain(16'h0040, 6'd0, 0, 1'b0, -1);
    n_checks++; if (hs_data.size() != 16) begin n_fail++; $display("FAIL sat_count got %0d exp 16", hs_data.size()); end
    else begin
      n_checks++; if (hs_data[0] != 32767)  begin n_fail++; $display("FAIL sat_pos got %0d exp 32767", hs_data[0]); end
      n_checks++; if (hs_data[1] != -32768) begin n_fail++; $display("FAIL sat_neg got %0d exp -32768", hs_data[1]); end
      for (int i = 3; i < 16; i++) begin
        n_checks++; if (hs_data[i] != model_q(snap_ref[i/4][i%4], 0)) begin n_fail++;
          $display("FAIL sat_model[%0d] got %0d exp %0d", i, hs_data[i], model_q(snap_ref[i/4][i%4], 0)); end
      end
    end
    acc[0][2] = -40'sd3;
    run_drain(16'h0040, 6'd1, 0, 1'b0, -1);
    n_checks++; if (hs_data.size() != 16) begin n_fail++; $display("FAIL floor_count got %0d exp 16", hs_data.size()); end
    else begin
      n_checks++; if (hs_data[2] != -2) begin n_fail++; $display("FAIL floor_shift got %0d exp -2", hs_data[2]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] b;
    logic [5:0]  s;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) acc[i/4][i%4] = rand_acc();
      b = 16'($urandom());
      s = 6'($urandom_range(0, 30));
      run_drain(b, s, 2, 1'b0, -1);
      n_checks++; if (timed_out || hs_data.size() != 16) begin n_fail++;
        $display("FAIL rand%0d_count got %0d timeout %0d exp 16", t, hs_data.size(), timed_out); end
      for (int i = 0; i < hs_data.size() && i < 16; i++) begin
        n_checks++; if (hs_data[i] != model_q(snap_ref[i/4][i%4], int'(s)) || hs_addr[i] != ((int'(b) + i) & 16'hFFFF)) begin
          n_fail++; $display("FAIL rand%0d_elem[%0d] got %0d@%h exp %0d@%h", t, i, hs_data[i], hs_addr[i],
                             model_q(snap_ref[i/4][i%4], int'(s)), (int'(b) + i) & 16'hFFFF); end
      end
      n_checks++; if (stall_errs != 0 || clear_count != 1) begin n_fail++;
        $display("FAIL rand%0d_stall_clear got %0d/%0d exp 0/1", t, stall_errs, clear_count); end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 16; i++) acc[i/4][i%4] = rand_acc();
    run_drain(16'h3000, 6'd4, 1, 1'b0, -1);
    n_checks++; if (stall_errs != 0) begin n_fail++; $display("FAIL stall_stability got %0d errs exp 0", stall_errs); end
    n_checks++; if (hs_data.size() != 16) begin n_fail++; $display("FAIL stall_count got %0d exp 16", hs_data.size()); end
    for (int i = 0; i < hs_data.size() && i < 16; i++) begin
      n_checks++; if (hs_data[i] != model_q(snap_ref[i/4][i%4], 4) || hs_addr[i] != 16'h3000 + i) begin n_fail++;
        $display("FAIL stall_elem[%0d] got %0d@%h exp %0d@%h", i, hs_data[i], hs_addr[i],
                 model_q(snap_ref[i/4][i%4], 4), 16'h3000 + i); end
    end
    n_checks++; if (done_cycle != 49) begin n_fail++; $display("FAIL stall_done_cycle got %0d exp 49", done_cycle); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) acc[i/4][i%4] = rand_acc();
    run_drain(16'h0200, 6'd0, 0, 1'b0, 5);
    n_checks++; if (hs_addr.size() != 5 || wr_if.wr_valid !== 1'b1) begin n_fail++;
      $display("FAIL midrst_pre got %0d hs valid %b exp 5 hs valid 1", hs_addr.size(), wr_if.wr_valid); end
    #2 rstn = 1'b0;
    #1;
    n_checks++; if ({pe_clear, wr_if.wr_valid, busy, done} !== 4'b0) begin n_fail++;
      $display("FAIL midrst_ctrl got %b exp 0000", {pe_clear, wr_if.wr_valid, busy, done}); end
    n_checks++; if (wr_if.wr_addr !== 16'h0 || wr_if.wr_data !== 16'sh0) begin n_fail++;
      $display("FAIL midrst_bus got %h/%h exp 0000/0000", wr_if.wr_addr, wr_if.wr_data); end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 16; i++) acc[i/4][i%4] = rand_acc();
    run_drain(16'h0AB0, 6'd2, 2, 1'b0, -1);
    n_checks++; if (hs_data.size() != 16) begin n_fail++; $display("FAIL midrst_count got %0d exp 16", hs_data.size()); end
    else begin
      n_checks++; if (hs_addr[0] != 16'h0AB0 || hs_data[0] != model_q(snap_ref[0][0], 2)) begin n_fail++;
        $display("FAIL midrst_first got %0d@%h exp %0d@0ab0", hs_data[0], hs_addr[0], model_q(snap_ref[0][0], 2)); end
      n_checks++; if (hs_addr[15] != 16'h0ABF || hs_data[15] != model_q(snap_ref[3][3], 2)) begin n_fail++;
        $display("FAIL midrst_last got %0d@%h exp %0d@0abf", hs_data[15], hs_addr[15], model_q(snap_ref[3][3], 2)); end
    end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 16; i++) acc[i/4][i%4] = rand_acc();
    run_drain(16'hFFF8, 6'd0, 0, 1'b1, -1);
    n_checks++; if (hs_addr.size() != 16 || done_cycle != 17) begin n_fail++;
      $display("FAIL ign_count got %0d done %0d exp 16 done 17", hs_addr.size(), done_cycle); end
    for (int i = 0; i < hs_addr.size() && i < 16; i++) begin
      n_checks++; if (hs_addr[i] != ((16'hFFF8 + i) & 16'hFFFF) || hs_data[i] != model_q(snap_ref[i/4][i%4], 0)) begin
        n_fail++; $display("FAIL ign_wrap[%0d] got %0d@%h exp %0d@%h", i, hs_data[i], hs_addr[i],
                           model_q(snap_ref[i/4][i%4], 0), (16'hFFF8 + i) & 16'hFFFF); end
    end
    n_checks++; if (clear_count != 1) begin n_fail++; $display("FAIL ign_clear got %0d exp 1", clear_count); end
    @(negedge clk);
    start = 1'b0;
    n_checks++; if ({wr_if.wr_valid, busy, pe_clear} !== 3'b000) begin n_fail++;
      $display("FAIL ign_done_start got %b exp 000", {wr_if.wr_valid, busy, pe_clear}); end
    @(negedge clk);
    n_checks++; if ({wr_if.wr_valid, busy} !== 2'b00) begin n_fail++;
      $display("FAIL ign_not_queued got %b exp 00", {wr_if.wr_valid, busy}); end
  endtask

  task automatic test_relu();
    int exp_neg;
    for (int i = 0; i < 16; i++) acc[i/4][i%4] = rand_acc();
    acc[0][0] = -40'sd500;
    acc[0][1] = 40'sd500;
`ifdef RELU_EN
    exp_neg = 0;
`else
    exp_neg = -500;
`endif
    run_drain(16'h0800, 6'd0, 0, 1'b0, -1);
    n_checks++; if (hs_data.size() != 16) begin n_fail++; $display("FAIL relu_count got %0d exp 16", hs_data.size()); end
    else begin
      n_checks++; if (hs_data[0] != exp_neg) begin n_fail++; $display("FAIL relu_neg got %0d exp %0d", hs_data[0], exp_neg); end
      n_checks++; if (hs_data[1] != 500) begin n_fail++; $display("FAIL relu_pos got %0d exp 500", hs_data[1]); end
    end
    n_checks++; if (clear_count != 1) begin n_fail++; $display("FAIL relu_clear got %0d exp 1", clear_count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) acc[i/4][i%4] = rand_acc();
    run_drain(16'h1000, 6'd5, 0, 1'b0, -1);
    for (int i = 0; i < 16; i++) acc[i/4][i%4] = rand_acc();
    run_drain(16'h2000, 6'd9, 0, 1'b0, -1);
    n_checks++; if (done_cycle != 17 || hs_data.size() != 16 || clear_count != 1) begin n_fail++;
      $display("FAIL b2b_timing got done %0d count %0d clear %0d exp 17/16/1", done_cycle, hs_data.size(), clear_count); end
    for (int i = 0; i < hs_data.size() && i < 16; i++) begin
      n_checks++; if (hs_data[i] != model_q(snap_ref[i/4][i%4], 9) || hs_addr[i] != 16'h2000 + i) begin n_fail++;
        $display("FAIL b2b_elem[%0d] got %0d@%h exp %0d@%h", i, hs_data[i], hs_addr[i],
                 model_q(snap_ref[i/4][i%4], 9), 16'h2000 + i); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_saturation();
    test_random();
    test_stall();
    test_reset_mid();
    test_start_ignored();
    test_relu();
    test_back_to_back();
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL final_timeout got timeout exp done"); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish before 500us");
    $fatal(1, "watchdog expired");
  end

endmodule
